// File: rtl/lab3_pkg.sv
// -----------------------------------------------------------------------------
// lab3_pkg
//   Definitions shared by the Lab3 tail-light controller blocks: the 3-bit
//   state code that the next-state logic, the state register and the lamp
//   sequencer all use, and the lamp pattern constants.
//
//   Contents:
//     state_e       - 3-bit state code (IDLE, TURN_LEFT, TURN_RIGHT, HAZARDS)
//     LAMPS_OFF     - all three lamps of one side dark
//     LAMPS_ALL     - all three lamps of one side lit
//     decode_state  - maps a raw 3-bit code to a defined state; any code
//                     outside the four defined ones is folded onto IDLE
// -----------------------------------------------------------------------------
package lab3_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TURN_LEFT  = 3'd1,
        TURN_RIGHT = 3'd2,
        HAZARDS    = 3'd3
    } state_e;

    localparam logic [2:0] LAMPS_OFF = 3'b000;
    localparam logic [2:0] LAMPS_ALL = 3'b111;

    // Undefined codes (3'd4..3'd7) behave exactly like IDLE so that a
    // corrupted state register can never light a lamp.
    function automatic state_e decode_state(input logic [2:0] code);
        state_e result;
        case (code)
            3'd0:    result = IDLE;
            3'd1:    result = TURN_LEFT;
            3'd2:    result = TURN_RIGHT;
            3'd3:    result = HAZARDS;
            default: result = IDLE;
        endcase
        return result;
    endfunction

endpackage : lab3_pkg

// File: rtl/taillight_sequencer_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Step-rate prescaler for the tail-light sequencer. Counts 0..TICK_DIV-1
//   and wraps, raising tick for exactly the one cycle in which the count
//   equals TICK_DIV-1.
//
//   Parameters:
//     TICK_DIV - clock cycles per step, must be >= 2
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset (count=0, tick=0)
//     clear    in   synchronous clear of the count; wins over counting
//     tick     out  registered one-cycle step pulse
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick_q;
    logic             tick_d;

    // The terminal compare is an equality, and the increment is only taken
    // below LAST, so the counter never relies on binary wrap-around and works
    // for any TICK_DIV, power of two or not.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q == LAST) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
        // tick is registered alongside the count, so it is high exactly
        // while count_q holds LAST.
        tick_d = (count_d == LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : tick_divider

// File: rtl/taillight_sequencer.sv
// -----------------------------------------------------------------------------
// taillight_sequencer
//   Output stage of the Lab3 tail-light controller. Takes the current state
//   code and drives timed lamp patterns on three left and three right lamps.
//   Contains its own step-rate prescaler (tick_divider) and a 2-bit phase
//   counter. All outputs are registered.
//
//   Parameters:
//     CLK_HZ   - input clock frequency in Hz
//     STEP_HZ  - lamp step rate in Hz; CLK_HZ/STEP_HZ must be >= 2
//
//   Ports:
//     clk          in   system clock
//     reset_n      in   asynchronous active-low reset
//     state[2:0]   in   current state code (lab3_pkg encoding)
//     left_lamps   out  left lamps, bit0 innermost, bit2 outermost
//     right_lamps  out  right lamps, bit0 innermost, bit2 outermost
//     step_tick    out  one-cycle pulse on each pattern step
//
//   Patterns (phase advances on each step):
//     TURN_LEFT/RIGHT : 000 -> 001 -> 011 -> 111 -> 000 ... on the active side
//     HAZARDS         : both sides 000 / 111 alternating
//     IDLE            : both sides dark
// -----------------------------------------------------------------------------
module taillight_sequencer
    import lab3_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] state,
    output logic [2:0] left_lamps,
    output logic [2:0] right_lamps,
    output logic       step_tick
);

    localparam int TICK_DIV = CLK_HZ / STEP_HZ;

    state_e     state_q;
    state_e     state_d;
    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic [2:0] left_q;
    logic [2:0] left_d;
    logic [2:0] right_q;
    logic [2:0] right_d;
    logic       mode_change;
    logic       tick;
    logic [2:0] turn_bar;

    // -------------------------------------------------------------------------
    // Mode register input: sampled every clock, undefined codes become IDLE.
    // A mode change is judged on the folded code, so an undefined code seen
    // while already idle does not restart the counters.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = decode_state(state);
    end

    assign mode_change = (state_d != state_q);

    // -------------------------------------------------------------------------
    // Step prescaler. It is cleared on a mode change so the first step of
    // the new pattern lands a full TICK_DIV cycles after the change.
    // -------------------------------------------------------------------------
    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (mode_change),
        .tick    (tick)
    );

    // -------------------------------------------------------------------------
    // Phase counter. A mode change takes priority over a coincident tick, so
    // the new pattern always starts from phase 0. In HAZARDS only bit0 moves;
    // bit1 is already 0 because every entry into HAZARDS clears the phase.
    // -------------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        if (mode_change) begin
            phase_d = 2'd0;
        end else if (tick) begin
            if (state_q == HAZARDS) begin
                phase_d = {phase_q[1], ~phase_q[0]};
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Turn-signal bar graph: lamp gi is lit once the phase has passed gi,
    // giving 000, 001, 011, 111 for phases 0..3.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_turn_bar
            assign turn_bar[gi] = (phase_d > 2'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Lamp decode. Built from the next mode and next phase so the registered
    // lamps always equal decode(state_q, phase_q). Phase 0 is dark in every
    // mode, which is what blanks both sides on the cycle after a mode change
    // and keeps old and new patterns from ever mixing.
    // -------------------------------------------------------------------------
    always_comb begin
        left_d  = LAMPS_OFF;
        right_d = LAMPS_OFF;
        case (state_d)
            TURN_LEFT: begin
                left_d = turn_bar;
            end
            TURN_RIGHT: begin
                right_d = turn_bar;
            end
            HAZARDS: begin
                if (phase_d[0]) begin
                    left_d  = LAMPS_ALL;
                    right_d = LAMPS_ALL;
                end
            end
            default: begin
                left_d  = LAMPS_OFF;
                right_d = LAMPS_OFF;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, phase and lamp registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            left_q  <= LAMPS_OFF;
            right_q <= LAMPS_OFF;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign left_lamps  = left_q;
    assign right_lamps = right_q;
    assign step_tick   = tick;

endmodule : taillight_sequencer

// File: tb/tb_taillight_sequencer.sv
// -----------------------------------------------------------------------------
// tb_taillight_sequencer
//   Self-checking bench for taillight_sequencer with CLK_HZ=8, STEP_HZ=2
//   (TICK_DIV=4). A reference model tracks the number of clock edges since
//   the last reset or mode change and derives the expected prescaler, step
//   count and lamp pattern from it arithmetically. A table of hand-computed
//   vectors, a directed asynchronous-reset sequence and a randomized run
//   are all checked cycle by cycle against that model.
// -----------------------------------------------------------------------------
module tb_taillight_sequencer;

    localparam int DIV = 4;

    logic       clk;
    logic       reset_n;
    logic [2:0] state;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;
    logic       step_tick;

    taillight_sequencer #(
        .CLK_HZ  (8),
        .STEP_HZ (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state),
        .left_lamps  (left_lamps),
        .right_lamps (right_lamps),
        .step_tick   (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int         m_edges;   // clock edges since reset release / mode change
    logic [2:0] m_mode;    // folded mode code 0..3
    logic [2:0] bar_tab [4];

    function automatic logic [2:0] fold(input logic [2:0] s);
        return (s <= 3'd3) ? s : 3'd0;
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_mode  = 3'd0;
    endtask

    task automatic model_edge(input logic [2:0] s);
        if (fold(s) != m_mode) begin
            m_mode  = fold(s);
            m_edges = 0;
        end else begin
            m_edges = m_edges + 1;
        end
    endtask

    task automatic model_expect(output logic [2:0] el, output logic [2:0] er,
                                output logic et);
        int steps;
        steps = m_edges / DIV;
        et    = ((m_edges % DIV) == DIV - 1);
        el    = 3'b000;
        er    = 3'b000;
        case (m_mode)
            3'd1: el = bar_tab[steps % 4];
            3'd2: er = bar_tab[steps % 4];
            3'd3: if ((steps % 2) == 1) begin el = 3'b111; er = 3'b111; end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [2:0] el,
                         input logic [2:0] er, input logic et);
        total = total + 1;
        if ({left_lamps, right_lamps, step_tick} !== {el, er, et}) begin
            bad = bad + 1;
            $display("FAIL %s t=%0t: got L=%b R=%b tick=%b, want L=%b R=%b tick=%b",
                     name, $time, left_lamps, right_lamps, step_tick, el, er, et);
        end
    endtask

    task automatic check_model(input string name);
        logic [2:0] el;
        logic [2:0] er;
        logic       et;
        model_expect(el, er, et);
        check(name, el, er, et);
    endtask

    // Drive state at a negedge, clock once, compare at the next negedge.
    task automatic run_cycle(input logic [2:0] s, input string name);
        state = s;
        @(posedge clk);
        model_edge(s);
        @(negedge clk);
        check_model(name);
    endtask

    // Called at a negedge; reset is asserted between edges and the outputs
    // must already be dark before the next posedge.
    task automatic async_reset_pulse(input string name);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check({name, "_async"}, 3'b000, 3'b000, 1'b0);
        @(negedge clk);
        check({name, "_held"}, 3'b000, 3'b000, 1'b0);
        reset_n = 1'b1;
        $display("reset pulse %s at t=%0t", name, $time);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] s;
        int         hold;
        logic [2:0] el;
        logic [2:0] er;
        logic       et;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic [2:0] s, input int hold, input logic [2:0] el,
                       input logic [2:0] er, input logic et);
        vec_t v;
        v.s = s; v.hold = hold; v.el = el; v.er = er; v.et = et;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] cur;

        bar_tab[0] = 3'b000;
        bar_tab[1] = 3'b001;
        bar_tab[2] = 3'b011;
        bar_tab[3] = 3'b111;

        // IDLE: dark, tick every 4 cycles
        add(3'd0,  3, 3'b000, 3'b000, 1'b1);
        add(3'd0,  1, 3'b000, 3'b000, 1'b0);
        add(3'd0, 35, 3'b000, 3'b000, 1'b1);
        // TURN_LEFT full cycle
        add(3'd1,  1, 3'b000, 3'b000, 1'b0);
        add(3'd1,  3, 3'b000, 3'b000, 1'b1);
        add(3'd1,  1, 3'b001, 3'b000, 1'b0);
        add(3'd1,  4, 3'b011, 3'b000, 1'b0);
        add(3'd1,  4, 3'b111, 3'b000, 1'b0);
        add(3'd1,  4, 3'b000, 3'b000, 1'b0);
        add(3'd1,  4, 3'b001, 3'b000, 1'b0);
        // HAZARDS alternation
        add(3'd3,  1, 3'b000, 3'b000, 1'b0);
        add(3'd3,  4, 3'b111, 3'b111, 1'b0);
        add(3'd3,  4, 3'b000, 3'b000, 1'b0);
        add(3'd3,  3, 3'b000, 3'b000, 1'b1);
        add(3'd3,  1, 3'b111, 3'b111, 1'b0);
        // TURN_RIGHT up to 011, then switch to TURN_LEFT
        add(3'd2,  1, 3'b000, 3'b000, 1'b0);
        add(3'd2,  8, 3'b000, 3'b011, 1'b0);
        add(3'd1,  1, 3'b000, 3'b000, 1'b0);
        add(3'd1,  3, 3'b000, 3'b000, 1'b1);
        add(3'd1,  1, 3'b001, 3'b000, 1'b0);
        // Mode change on the same edge as a step
        add(3'd1,  3, 3'b001, 3'b000, 1'b1);
        add(3'd2,  1, 3'b000, 3'b000, 1'b0);
        add(3'd2,  3, 3'b000, 3'b000, 1'b1);
        add(3'd2,  1, 3'b000, 3'b001, 1'b0);
        // Undefined codes fold onto IDLE
        add(3'd6,  1, 3'b000, 3'b000, 1'b0);
        add(3'd7,  4, 3'b000, 3'b000, 1'b0);
        add(3'd5,  3, 3'b000, 3'b000, 1'b1);

        // ---------------- reset ----------------
        reset_n = 1'b0;
        state   = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", 3'b000, 3'b000, 1'b0);
        reset_n = 1'b1;
        check("post_release", 3'b000, 3'b000, 1'b0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].hold; k++) begin
                run_cycle(vecs[i].s, $sformatf("vec%0d_model", i));
            end
            check($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, vecs[i].et);
            $display("vec %0d: state=%0d x%0d -> L=%b R=%b tick=%b",
                     i, vecs[i].s, vecs[i].hold, left_lamps, right_lamps, step_tick);
        end

        // ---------------- async reset mid-HAZARDS ----------------
        run_cycle(3'd3, "haz_enter");
        for (int k = 0; k < 4; k++) run_cycle(3'd3, "haz_run");
        check("haz_lit", 3'b111, 3'b111, 1'b0);
        async_reset_pulse("haz");
        for (int k = 1; k <= 12; k++) begin
            run_cycle(3'd6, "code6");
            if (k == 3) check("code6_first_tick", 3'b000, 3'b000, 1'b1);
            if (k == 4) check("code6_dark", 3'b000, 3'b000, 1'b0);
        end
        $display("async reset sequence done at t=%0t", $time);

        // ---------------- randomized ----------------
        cur = 3'd0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 23) == 0) begin
                cur = 3'($urandom_range(0, 7));
                $display("rnd cycle %0d: state -> %0d", i, cur);
            end
            if ($urandom_range(0, 199) == 0) async_reset_pulse("rnd");
            run_cycle(cur, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_taillight_sequencer

// File: doc/taillight_sequencer.md
Name: taillight_sequencer

Overview:
- Downstream output stage of the Lab3 tail-light controller.
- Consumes the registered current-state code (IDLE / TURN_LEFT / TURN_RIGHT / HAZARDS) and produces the timed lamp patterns for three left and three right lamps.
- Contains its own step-rate prescaler and phase counter; all outputs are registered.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- STEP_HZ, 4, lamp step rate in Hz. TICK_DIV = CLK_HZ/STEP_HZ, must be >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- state  in  3  current state code from the state register, using the shared package encoding.
- left_lamps  out  3  left lamps; bit0 innermost, bit2 outermost.
- right_lamps  out  3  right lamps; bit0 innermost, bit2 outermost.
- step_tick  out  1  one-cycle pulse on each pattern step (debug/verification).

Behaviour:
- Reset is asynchronous; it applies immediately, regardless of clock. While reset_n=0:
  - left_lamps=000, right_lamps=000, step_tick=0.
  - Prescaler=0, phase=0, registered state=IDLE.
- Reset mid-sequence drops all lamps the same way. After release, the first step occurs TICK_DIV cycles later.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - step_tick=1 for exactly the one cycle in which the prescaler equals TICK_DIV-1; otherwise 0.
- Phase counter:
  - 2-bit, advances on step_tick only.
  - Wraps 3->0 in turn modes; toggles bit0 only in HAZARDS.
- Mode register: state is sampled every clock into state_q. Any code other than the four defined ones is treated as IDLE.
- Mode change (sampled state != state_q):
  - Prescaler and phase clear to 0 on that edge.
  - Both lamp outputs are 000 on the following cycle.
  - Outputs are therefore never a mix of the old and new patterns.
  - If the change coincides with a tick, the change wins: no phase advance.
- IDLE: both outputs 000; counters free-run but have no effect on outputs.
- TURN_LEFT:
  - right_lamps=000.
  - left_lamps by phase: 0->000, 1->001, 2->011, 3->111, then back to 000.
- TURN_RIGHT: mirror of TURN_LEFT, with left_lamps=000 and right_lamps following the same sequence.
- HAZARDS: phase bit0=0 -> both 000; phase bit0=1 -> both 111. Toggles every tick.
- Output timing:
  - Lamps are a registered function of (state_q, phase).
  - Lamps update on the clock edge after step_tick.
  - Steady-state period: 4*TICK_DIV cycles for turn modes, 2*TICK_DIV cycles for hazards.
- Widths:
  - Prescaler width = clog2(TICK_DIV).
  - No arithmetic overflow is permitted; the terminal compare is equality with TICK_DIV-1.

Decomposition:
- Shared package lab3_pkg holds:
  - 3-bit state codes: IDLE=3'd0, TURN_LEFT=3'd1, TURN_RIGHT=3'd2, HAZARDS=3'd3.
  - Lamp pattern constants: LAMPS_OFF=3'b000, LAMPS_ALL=3'b111.
- The next-state logic and state register use the same package.
- One sub-module: tick_divider.
  - Parameterised by TICK_DIV; ports clk, reset_n, clear, tick.
  - clear synchronously zeros the count with priority over counting.
- Pattern decode and phase logic stay in taillight_sequencer.

Test Plan (CLK_HZ=8, STEP_HZ=2, so TICK_DIV=4):
- Reset, then state=IDLE for 40 cycles -> lamps stay 000/000; step_tick pulses every 4 cycles.
- state=TURN_LEFT held -> left_lamps steps 000, 001, 011, 111, 000 at 4-cycle intervals; right_lamps stays 000; period 16 cycles.
- state=HAZARDS held -> both outputs alternate 000/111 every 4 cycles, always equal to each other.
- Switch TURN_RIGHT->TURN_LEFT while right_lamps=011 -> next cycle both 000; left_lamps=001 exactly 4 cycles later.
- Mode change on the same cycle as step_tick -> no phase advance; both outputs 000; next step 4 cycles later.
- Assert reset_n=0 asynchronously mid-HAZARDS at 111 -> outputs 000 without waiting for a clock edge. Then state=3'd6 after release -> treated as IDLE, outputs stay 000.
